// File: rtl/stream_demux_pkg.sv
// ============================================================================
// stream_demux_pkg : shared slot-state type and drop-counter constants
// Revision 1.0
// ============================================================================
`default_nettype none

package stream_demux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  localparam int                    DROP_CNT_W   = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // Saturating increment: the counter parks at its maximum instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_demux_slot.sv
// ============================================================================
// stream_demux_slot : one-entry output register for a single demux channel
// Revision 1.0
// ============================================================================
`default_nettype none

module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             can_load
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A full slot may still take a word when its consumer drains it this cycle.
  assign can_load  = (state_q == EMPTY) || out_ready;
  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = FULL;
      data_d  = load_data;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stream_demux.sv
// ============================================================================
// stream_demux : 1-to-N stream demultiplexer with broadcast and drop counting
// Revision 1.0
// ============================================================================
`default_nettype none

module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [DROP_CNT_W-1:0]     drop_cnt
);

  logic [CHANNELS-1:0]   sel_hit;
  logic [CHANNELS-1:0]   can_load;
  logic [CHANNELS-1:0]   load;
  logic                  in_range;
  logic                  accept;
  logic                  drop;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_hit[k] = (int'(in_sel) == k);
    end
  end

  assign in_range = |sel_hit;

  // Out-of-range words are always taken so the producer never stalls on them.
  always_comb begin
    if (in_bcast)      in_ready = &can_load;
    else if (in_range) in_ready = |(sel_hit & can_load);
    else               in_ready = 1'b1;
  end

  assign accept = in_valid && in_ready;
  assign drop   = accept && !in_bcast && !in_range;
  assign load   = accept ? (in_bcast ? {CHANNELS{1'b1}} : sel_hit) : '0;

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
      stream_demux_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load[k]),
        .load_data (in_data),
        .out_ready (out_ready[k]),
        .out_valid (out_valid[k]),
        .out_data  (out_data[k*WIDTH +: WIDTH]),
        .can_load  (can_load[k])
      );
    end
  endgenerate

  always_comb begin
    drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_demux.sv
// ============================================================================
// tb_stream_demux : stream_demux bench with behavioural slot model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_stream_demux;

  localparam int W = 8;
  localparam int C = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Four-channel instance
  logic          rst4_n;
  logic [W-1:0]  in_data4;
  logic [1:0]    in_sel4;
  logic          bcast4, valid4, ready4;
  logic [C*W-1:0] out_data4;
  logic [C-1:0]  out_valid4, out_ready4;
  logic [15:0]   drop4;

  // Three-channel instance for out-of-range selects
  logic          rst3_n;
  logic [W-1:0]  in_data3;
  logic [1:0]    in_sel3;
  logic          bcast3, valid3, ready3;
  logic [3*W-1:0] out_data3;
  logic [2:0]    out_valid3, out_ready3;
  logic [15:0]   drop3;
  logic          done3 = 1'b0;

  stream_demux #(.WIDTH(W), .CHANNELS(C)) dut4 (
    .clk(clk), .rst_n(rst4_n), .in_data(in_data4), .in_sel(in_sel4),
    .in_bcast(bcast4), .in_valid(valid4), .in_ready(ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .drop_cnt(drop4)
  );

  stream_demux #(.WIDTH(W), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .in_data(in_data3), .in_sel(in_sel3),
    .in_bcast(bcast3), .in_valid(valid3), .in_ready(ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .drop_cnt(drop3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of the four-channel instance
  bit          m_full [C];
  logic [7:0]  m_data [C];
  logic [15:0] m_drop;

  function automatic bit exp_ready();
    bit r;
    if (bcast4) begin
      r = 1'b1;
      for (int k = 0; k < C; k++) if (m_full[k] && !out_ready4[k]) r = 1'b0;
    end else if (int'(in_sel4) >= C) begin
      r = 1'b1;
    end else begin
      r = !m_full[in_sel4] || out_ready4[in_sel4];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst4_n) begin
    if (!rst4_n) begin
      for (int k = 0; k < C; k++) begin
        m_full[k] = 1'b0;
        m_data[k] = '0;
      end
      m_drop = '0;
    end else begin
      bit acc;
      acc = valid4 && exp_ready();
      for (int k = 0; k < C; k++) begin
        if (acc && (bcast4 || int'(in_sel4) == k)) begin
          m_full[k] = 1'b1;
          m_data[k] = in_data4;
        end else if (m_full[k] && out_ready4[k]) begin
          m_full[k] = 1'b0;
        end
      end
      if (acc && !bcast4 && int'(in_sel4) >= C && m_drop != 16'hFFFF) m_drop = m_drop + 1;
    end
  end

  always @(negedge clk) begin
    logic [C-1:0]   ev;
    logic [C*W-1:0] ed;
    for (int k = 0; k < C; k++) begin
      ev[k]        = m_full[k];
      ed[k*W +: W] = m_full[k] ? m_data[k] : 8'h00;
    end
    chk("model_out_valid", 64'(out_valid4), 64'(ev));
    chk("model_out_data",  64'(out_data4),  64'(ed));
    chk("model_in_ready",  64'(ready4),     64'(exp_ready()));
    chk("model_drop_cnt",  64'(drop4),      64'(m_drop));
  end

  // Out-of-range drops and counter saturation on the three-channel instance
  initial begin
    in_data3 = '0; in_sel3 = 2'd3; bcast3 = 1'b0; valid3 = 1'b0; out_ready3 = '0;
    wait (rst3_n === 1'b1);
    step();
    valid3 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_data3   = W'($urandom);
      out_ready3 = 3'($urandom);
      #1 chk("oor_in_ready", 64'(ready3), 64'd1);
      step();
      chk("oor_out_valid", 64'(out_valid3), 64'd0);
      chk("oor_drop_cnt",  64'(drop3),      64'(i));
    end
    valid3 = 1'b0;
    step();
    chk("oor_idle_hold", 64'(drop3), 64'd5);
    valid3 = 1'b1;
    for (int i = 6; i <= 65534; i++) step();
    chk("oor_preload_fffe", 64'(drop3), 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("oor_saturate", 64'(drop3), 64'hFFFF);
    end
    chk("oor_no_output", 64'(out_valid3), 64'd0);
    valid3 = 1'b0;
    done3  = 1'b1;
  end

  initial begin
    int n;
    rst4_n = 1'b0; rst3_n = 1'b0;
    in_data4 = '0; in_sel4 = '0; bcast4 = 1'b0; valid4 = 1'b0; out_ready4 = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst4_n = 1'b1; rst3_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid4), 64'd0);
    chk("rst_out_data",  64'(out_data4),  64'd0);
    chk("rst_drop_cnt",  64'(drop4),      64'd0);
    step();

    // Unicast sweep
    for (int s = 0; s < C; s++) begin
      logic [3:0]  ev;
      logic [31:0] ed;
      ev = 4'b0001 << s;
      ed = 32'h0000_00A5 << (8 * s);
      in_data4 = 8'hA5; in_sel4 = 2'(s); valid4 = 1'b1;
      step();
      chk("uni_out_valid", 64'(out_valid4), 64'(ev));
      chk("uni_out_data",  64'(out_data4),  64'(ed));
      valid4 = 1'b0;
      step();
    end

    // Backpressure on channel 2
    out_ready4 = 4'b1011; in_sel4 = 2'd2; in_data4 = 8'h11; valid4 = 1'b1;
    step();
    chk("bp_first_valid", 64'(out_valid4), 64'b0100);
    chk("bp_first_data",  64'(out_data4[23:16]), 64'h11);
    in_data4 = 8'h22;
    #1 chk("bp_ready_low", 64'(ready4), 64'd0);
    step();
    chk("bp_first_held", 64'(out_data4[23:16]), 64'h11);
    out_ready4 = 4'hF;
    #1 chk("bp_ready_high", 64'(ready4), 64'd1);
    step();
    chk("bp_second_data",  64'(out_data4[23:16]), 64'h22);
    chk("bp_second_valid", 64'(out_valid4), 64'b0100);
    valid4 = 1'b0;
    step();
    chk("bp_drained", 64'(out_valid4), 64'd0);

    // Broadcast blocked by a stalled slot, then released
    out_ready4 = 4'b1101; in_sel4 = 2'd1; in_data4 = 8'h55; valid4 = 1'b1;
    step();
    chk("bc_pre_valid", 64'(out_valid4), 64'b0010);
    bcast4 = 1'b1; in_data4 = 8'h77;
    #1 chk("bc_ready_low", 64'(ready4), 64'd0);
    step();
    chk("bc_no_load_valid", 64'(out_valid4), 64'b0010);
    chk("bc_no_load_data",  64'(out_data4),  64'h0000_5500);
    out_ready4 = 4'hF;
    #1 chk("bc_ready_high", 64'(ready4), 64'd1);
    step();
    chk("bc_all_valid", 64'(out_valid4), 64'hF);
    chk("bc_all_data",  64'(out_data4),  64'h7777_7777);
    valid4 = 1'b0; bcast4 = 1'b0;
    step();

    // Full-rate stream into channel 0
    out_ready4 = 4'hF; in_sel4 = 2'd0; valid4 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data4 = 8'(i);
      #1 chk("fr_in_ready", 64'(ready4), 64'd1);
      step();
      chk("fr_data",  64'(out_data4[7:0]), 64'(i));
      chk("fr_valid", 64'(out_valid4),     64'b0001);
    end
    valid4 = 1'b0;
    step();

    // Randomized traffic checked by the model
    repeat (3000) begin
      valid4     = ($urandom_range(0, 3) != 0);
      bcast4     = ($urandom_range(0, 7) == 0);
      in_sel4    = 2'($urandom);
      in_data4   = 8'($urandom);
      out_ready4 = 4'($urandom);
      step();
    end

    // Asynchronous reset with every slot full
    out_ready4 = 4'h0; bcast4 = 1'b0; valid4 = 1'b0;
    repeat (2) step();
    out_ready4 = 4'hF;
    step();
    out_ready4 = 4'h0; bcast4 = 1'b1; in_data4 = 8'h3C; valid4 = 1'b1;
    step();
    chk("ar_full", 64'(out_valid4), 64'hF);
    valid4 = 1'b0; bcast4 = 1'b0;
    #2 rst4_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid4), 64'd0);
    chk("ar_out_data",  64'(out_data4),  64'd0);
    chk("ar_drop_cnt",  64'(drop4),      64'd0);
    @(negedge clk);
    @(negedge clk);
    rst4_n = 1'b1;
    in_sel4 = 2'd3; in_data4 = 8'h99; valid4 = 1'b1;
    #1 chk("ar_ready_after", 64'(ready4), 64'd1);
    step();
    chk("ar_first_accept", 64'(out_valid4), 64'b1000);
    valid4 = 1'b0;
    step();

    n = 0;
    while (!done3 && n < 80000) begin
      @(posedge clk);
      n++;
    end
    if (!done3) begin
      total++;
      bad++;
      $display("FAIL oor_timeout: got not-done expected done");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, >=1.
REQ-002 Parameter CHANNELS, default 4: output channel count, 2..16.
REQ-003 Parameter SEL_W, default $clog2(CHANNELS): select width.
REQ-004 clk  in  1  single clock; all state rising-edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_data  in  WIDTH  input word.
REQ-007 in_sel  in  SEL_W  target channel index.
REQ-008 in_bcast  in  1  1 = deliver word to every channel, in_sel ignored.
REQ-009 in_valid  in  1  input word present.
REQ-010 in_ready  out  1  input accepted this cycle when in_valid & in_ready.
REQ-011 out_data  out  CHANNELS*WIDTH  channel k word at bits [k*WIDTH +: WIDTH].
REQ-012 out_valid  out  CHANNELS  per-channel word present.
REQ-013 out_ready  in  CHANNELS  per-channel consumer accept.
REQ-014 drop_cnt  out  16  count of words dropped for out-of-range in_sel.

Function
REQ-015 Each channel SHALL hold a one-entry output register (slot): EMPTY or FULL.
REQ-016 Slot k SHALL go EMPTY->FULL on accept targeting k; FULL->EMPTY on out_valid[k] & out_ready[k] without new load; stay FULL on simultaneous drain and load, taking the new word.
REQ-017 out_valid[k] SHALL equal slot k FULL; out_data for an EMPTY slot SHALL be all zeros.
REQ-018 Latency SHALL be exactly 1 cycle: word accepted at edge N is visible on out_data/out_valid after edge N.
REQ-019 Unicast (in_bcast=0, in_sel<CHANNELS): in_ready SHALL be 1 iff slot in_sel is EMPTY or out_ready[in_sel]=1 (pass-through drain); combinational from slot state and out_ready only, not from in_valid.
REQ-020 Broadcast (in_bcast=1): in_ready SHALL be 1 iff every slot is EMPTY or draining this cycle; on accept all slots load in_data in the same edge; no partial broadcast.
REQ-021 Out-of-range (in_bcast=0, in_sel>=CHANNELS): in_ready SHALL be 1; the accepted word is discarded, no slot changes, drop_cnt increments by 1.
REQ-022 drop_cnt SHALL saturate at 16'hFFFF, never wrap.
REQ-023 Ordering per channel SHALL be preserved; a held word SHALL never be overwritten unless drained the same cycle.
REQ-024 out_valid[k] once asserted SHALL stay asserted with stable out_data[k] until out_ready[k] is sampled high.
REQ-025 in_valid=0 SHALL leave all slots and drop_cnt unchanged except for drains.

Reset
REQ-026 rst_n low SHALL immediately clear all slots to EMPTY, out_valid to 0, out_data to 0, drop_cnt to 0, regardless of clk.
REQ-027 Reset mid-transfer SHALL discard held words; first accept after deassertion obeys REQ-019/020 with all slots EMPTY.
REQ-028 in_ready MAY be asserted during reset but no state SHALL change until rst_n is sampled high.

Structure
REQ-029 Package stream_demux_pkg SHALL hold the slot-state enum (EMPTY, FULL), DROP_CNT_W=16 and DROP_CNT_MAX.
REQ-030 Per-channel slot SHALL be sub-module stream_demux_slot (ports: clk, rst_n, load, load_data, out_ready, out_valid, out_data, can_load), instantiated CHANNELS times by generate.
REQ-031 Top level SHALL contain only decode, in_ready combine, and drop counter.

Verification
REQ-032 Unicast sweep: WIDTH=8, CHANNELS=4, A=8'hA5, in_sel 0..3, all out_ready=1 -> only out_valid[sel]=1 next cycle, out_data[sel]=8'hA5, others zero.
REQ-033 Backpressure: out_ready[2]=0, two words to channel 2 -> first held, in_ready=0 for second until out_ready[2]=1; first word delivered, then second, none lost.
REQ-034 Broadcast: slot 1 FULL, out_ready[1]=0, in_bcast=1 -> in_ready=0, no slot loads; release out_ready[1] -> all 4 slots load same word in one edge.
REQ-035 Out-of-range: CHANNELS=3, in_sel=3, 5 valid words -> in_ready=1, out_valid stays 0, drop_cnt=5; preload 16'hFFFE + 3 drops -> 16'hFFFF.
REQ-036 Async reset: assert rst_n=0 mid-cycle with slots FULL -> out_valid=0, out_data=0, drop_cnt=0 before next clk edge.
REQ-037 Simultaneous drain+load on channel 0 at full rate, 100 words -> one word per cycle, in-order, in_ready continuously 1.
